// File: rtl/dma_pkg.sv
// Shared constants for the dma_copy block: register map,
// control/status bit positions and FSM state encodings.
package dma_pkg;

  localparam logic [4:0] REG_SRC    = 5'h00;
  localparam logic [4:0] REG_DST    = 5'h04;
  localparam logic [4:0] REG_LEN    = 5'h08;
  localparam logic [4:0] REG_CTRL   = 5'h0C;
  localparam logic [4:0] REG_STATUS = 5'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR     = 3'd3,
    S_WR_GAP = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/dma_regs.sv
// Register slave for dma_copy: one-shot handshake,
// SRC/DST/LEN working registers, CTRL/STATUS and irq.
module dma_regs
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic [3:0]       wstrb,
  input  logic [4:0]       addr,
  input  logic [31:0]      data_i,
  output logic             ready,
  output logic [31:0]      data_o,
  input  logic             busy,
  input  logic             fin,
  input  logic             adv,
  output logic             start,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             irq
);

  logic        hold;
  logic        acc;
  logic        wr;
  logic        wr_ok;
  logic        w1c;
  logic        done_set;
  logic        done;
  logic        irq_en;
  logic [31:0] rdata;

  // An access is accepted once per select assertion.
  assign acc      = select & ~hold;
  assign wr       = acc & (wstrb != 4'h0);
  assign wr_ok    = wr & ~busy;
  assign start    = wr_ok & (addr == REG_CTRL)
                  & data_i[CTRL_START];
  assign w1c      = wr & (addr == REG_STATUS)
                  & data_i[STAT_DONE];
  assign done_set = fin | (start & (len == '0));

  always_comb begin
    rdata = 32'h0;
    case (addr)
      REG_SRC:    rdata = src;
      REG_DST:    rdata = dst;
      REG_LEN:    rdata = 32'(len);
      REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
      REG_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done;
      end
      default:    rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold   <= 1'b0;
      ready  <= 1'b0;
      data_o <= 32'h0;
      src    <= 32'h0;
      dst    <= 32'h0;
      len    <= '0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      hold   <= select;
      ready  <= acc;
      data_o <= acc ? rdata : 32'h0;
      if (adv) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len - LEN_W'(1);
      end else if (wr_ok) begin
        case (addr)
          REG_SRC: src <= {data_i[31:2], 2'b00};
          REG_DST: dst <= {data_i[31:2], 2'b00};
          REG_LEN: len <= data_i[LEN_W-1:0];
          default: ;
        endcase
      end
      if (wr && addr == REG_CTRL)
        irq_en <= data_i[CTRL_IRQ_EN];
      // A completion in the same cycle as a W1C wins.
      if (done_set)
        done <= 1'b1;
      else if (start | w1c)
        done <= 1'b0;
      irq <= done & irq_en;
    end
  end

endmodule

// File: rtl/dma_copy.sv
// Word-copy DMA initiator: alternates single reads and
// writes on the native bus, configured via dma_regs.
module dma_copy
  import dma_pkg::*;
#(
  parameter int BASE_LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        select,
  input  logic [3:0]  wstrb,
  input  logic [4:0]  addr,
  input  logic [31:0] data_i,
  output logic        ready,
  output logic [31:0] data_o,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        irq
);

  state_t                    state;
  state_t                    state_nx;
  logic [31:0]               rd_buf;
  logic [31:0]               src;
  logic [31:0]               dst;
  logic [BASE_LEN_WIDTH-1:0] len;
  logic                      start;
  logic                      busy;
  logic                      fin;
  logic                      adv;

  assign busy = (state != S_IDLE);
  assign fin  = (state == S_DONE);
  assign adv  = (state == S_WR) & m_ready;

  dma_regs #(
    .LEN_W (BASE_LEN_WIDTH)
  ) u_regs (
    .clk    (clk),
    .reset  (reset),
    .select (select),
    .wstrb  (wstrb),
    .addr   (addr),
    .data_i (data_i),
    .ready  (ready),
    .data_o (data_o),
    .busy   (busy),
    .fin    (fin),
    .adv    (adv),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .irq    (irq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      rd_buf <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == S_RD && m_ready)
        rd_buf <= m_rdata;
    end
  end

  // Bus outputs decode from state; src/dst are frozen
  // while busy, so the request is stable until m_ready.
  always_comb begin
    state_nx = state;
    m_valid  = 1'b0;
    m_addr   = 32'h0;
    m_wdata  = 32'h0;
    m_wstrb  = 4'h0;
    case (state)
      S_IDLE: begin
        if (start && len != '0)
          state_nx = S_RD;
      end
      S_RD: begin
        m_valid = 1'b1;
        m_addr  = src;
        if (m_ready)
          state_nx = S_RD_GAP;
      end
      S_RD_GAP: state_nx = S_WR;
      S_WR: begin
        m_valid = 1'b1;
        m_addr  = dst;
        m_wdata = rd_buf;
        m_wstrb = 4'hF;
        if (m_ready)
          state_nx = S_WR_GAP;
      end
      S_WR_GAP: begin
        if (len != '0)
          state_nx = S_RD;
        else
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register accesses plus a
// stalling memory model that scoreboards bus transfers.
module tb_dma_copy;

  logic        clk;
  logic        reset;
  logic        select;
  logic [3:0]  wstrb;
  logic [4:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        irq;

  dma_copy #(.BASE_LEN_WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .select  (select),
    .wstrb   (wstrb),
    .addr    (addr),
    .data_i  (data_i),
    .ready   (ready),
    .data_o  (data_o),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          stall = 0;
  logic        hold_wr = 1'b0;
  logic        valid_seen = 1'b0;
  int          cnt = 0;
  logic [67:0] lat;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic push_copy(input logic [31:0] s,
                           input logic [31:0] d,
                           input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      t.wr = 1'b0; t.a = s + 32'(4 * i); t.d = 32'h0;
      sb.push_back(t);
      t.wr = 1'b1; t.a = d + 32'(4 * i); t.d = rd_val(s + 32'(4 * i));
      sb.push_back(t);
    end
  endtask

  // Memory model: responds after `stall` waiting cycles.
  always @(negedge clk) begin
    txn_t t;
    if (reset || !m_valid) begin
      m_ready = 1'b0;
      cnt = 0;
    end else begin
      valid_seen = 1'b1;
      if (cnt == 0)
        lat = {m_addr, m_wstrb, m_wdata};
      else begin
        chk("stable_addr", m_addr, lat[67:36]);
        chk("stable_ctl", {m_wstrb, 28'h0}, {lat[35:32], 28'h0});
        chk("stable_wdata", m_wdata, lat[31:0]);
      end
      if ((hold_wr && m_wstrb != 4'h0) || cnt < stall) begin
        m_ready = 1'b0;
        cnt++;
      end else begin
        m_ready = 1'b1;
        m_rdata = rd_val(m_addr);
        cnt = 0;
        if (sb.size() == 0)
          chk("extra_txn", m_addr, 32'hDEAD_BEEF);
        else begin
          t = sb.pop_front();
          chk("bus_addr", m_addr, t.a);
          chk("bus_wstrb", {28'h0, m_wstrb}, t.wr ? 32'hF : 32'h0);
          if (t.wr)
            chk("bus_wdata", m_wdata, t.d);
        end
      end
    end
  end

  task automatic reg_acc(input logic [4:0] a,
                         input logic [3:0] ws,
                         input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    @(negedge clk);
    select = 1'b1; addr = a; wstrb = ws; data_i = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 8);
    chk("reg_ready", {31'h0, ready}, 32'h1);
    q = data_o;
    select = 1'b0; wstrb = 4'h0;
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] q;
    reg_acc(a, 4'hF, d, q);
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [31:0] q);
    reg_acc(a, 4'h0, 32'h0, q);
  endtask

  task automatic wait_idle();
    logic [31:0] q;
    int n;
    n = 0;
    do begin
      reg_rd(5'h10, q);
      n++;
    end while (q[0] && n < 300);
    chk("busy_timeout", {31'h0, q[0]}, 32'h0);
  endtask

  task automatic start_copy(input logic [31:0] s,
                            input logic [31:0] d,
                            input logic [31:0] n);
    reg_wr(5'h00, s);
    reg_wr(5'h04, d);
    reg_wr(5'h08, n);
    reg_wr(5'h0C, 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] q;
    txn_t t;
    int n;
    reset = 1'b1; select = 1'b0; wstrb = 4'h0;
    addr = 5'h0; data_i = 32'h0; m_rdata = 32'h0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reg_rd(5'h10, q); chk("rst_status", q, 32'h0);
    reg_rd(5'h08, q); chk("rst_len", q, 32'h0);

    // basic copy of three words
    push_copy(32'h20000, 32'h20100, 3);
    start_copy(32'h20000, 32'h20100, 3);
    wait_idle();
    chk("t1_sb_empty", sb.size(), 0);
    reg_rd(5'h10, q); chk("t1_status", q, 32'h2);
    reg_rd(5'h08, q); chk("t1_len", q, 32'h0);
    reg_rd(5'h00, q); chk("t1_src", q, 32'h2000C);
    reg_rd(5'h04, q); chk("t1_dst", q, 32'h2010C);
    reg_rd(5'h14, q); chk("t1_unmapped", q, 32'h0);

    // zero length: done with no bus traffic, irq path
    valid_seen = 1'b0;
    reg_wr(5'h10, 32'h2);
    reg_rd(5'h10, q); chk("t2_w1c", q, 32'h0);
    reg_wr(5'h08, 32'h0);
    reg_wr(5'h0C, 32'h3);
    reg_rd(5'h10, q); chk("t2_status", q, 32'h2);
    reg_rd(5'h0C, q); chk("t2_ctrl", q, 32'h2);
    chk("t2_irq", {31'h0, irq}, 32'h1);
    chk("t2_no_valid", {31'h0, valid_seen}, 32'h0);
    reg_wr(5'h10, 32'h2);
    repeat (2) @(negedge clk);
    chk("t2_irq_clr", {31'h0, irq}, 32'h0);

    // stalled memory
    stall = 5;
    push_copy(32'h1000, 32'h3000, 2);
    start_copy(32'h1000, 32'h3000, 2);
    wait_idle();
    chk("t3_sb_empty", sb.size(), 0);
    reg_rd(5'h10, q); chk("t3_status", q, 32'h2);

    // START and SRC write while busy are ignored
    stall = 3;
    push_copy(32'h4000, 32'h5000, 3);
    start_copy(32'h4000, 32'h5000, 3);
    reg_wr(5'h00, 32'h30000);
    reg_wr(5'h0C, 32'h1);
    reg_rd(5'h10, q); chk("t4_busy", q, 32'h1);
    wait_idle();
    chk("t4_sb_empty", sb.size(), 0);
    reg_rd(5'h00, q); chk("t4_src", q, 32'h400C);

    // address wrap
    stall = 0;
    push_copy(32'hFFFF_FFFC, 32'h6000, 2);
    start_copy(32'hFFFF_FFFF, 32'h6000, 2);
    wait_idle();
    chk("t5_sb_empty", sb.size(), 0);
    reg_rd(5'h00, q); chk("t5_src", q, 32'h4);

    // reset during a stalled write
    hold_wr = 1'b1;
    t.wr = 1'b0; t.a = 32'h7000; t.d = 32'h0;
    sb.push_back(t);
    start_copy(32'h7000, 32'h8000, 1);
    n = 0;
    while (!(m_valid && m_wstrb == 4'hF) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_wr", {28'h0, m_wstrb}, 32'hF);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid_drop", {31'h0, m_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    hold_wr = 1'b0;
    chk("t6_sb_empty", sb.size(), 0);
    reg_rd(5'h10, q); chk("t6_status", q, 32'h0);
    push_copy(32'h7000, 32'h8000, 1);
    start_copy(32'h7000, 32'h8000, 1);
    wait_idle();
    chk("t6b_sb_empty", sb.size(), 0);
    reg_rd(5'h10, q); chk("t6b_status", q, 32'h2);
    reg_rd(5'h04, q); chk("t6b_dst", q, 32'h8004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
